sarlock_key_ctrl: RTL and testbench

//  Sequential key-delivery controller for SarLock/XOR-locked netlists.

---
 rtl/sarlock_key_ctrl_pkg.sv | 22 ++
 rtl/sarlock_key_ctrl_if.sv | 29 ++
 rtl/sarlock_key_ctrl_shift.sv | 27 ++
 rtl/sarlock_key_ctrl.sv | 153 +++++++++++++++
 tb/tb_sarlock_key_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sarlock_key_ctrl_pkg.sv
// Shared types and helpers for the SarLock key-delivery controller.
package sarlock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    VALID,
    LOCKOUT
  } state_t;

  localparam int KEY_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = $clog2(KEY_W_DEF + 2);
  localparam int TMR_W       = $clog2(TIMEOUT_DEF + 1);

  // Even parity over key bits plus parity bit; zero-extension does not change the XOR.
  function automatic logic parity_ok(input logic [31:0] bits);
    return ~^bits;
  endfunction

endpackage

// File: rtl/sarlock_key_ctrl_if.sv
// Key source <-> key controller signal bundle.
interface sarlock_key_ctrl_if #(
  parameter int KEY_W    = 4,
  parameter int MAX_FAIL = 3
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic              key_start;
  logic              key_bit_vld;
  logic              key_bit;
  logic              key_zeroize;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              key_err;
  logic              busy;
  logic              lockout;
  logic [FAIL_W-1:0] fail_cnt;

  modport master (
    output key_start, key_bit_vld, key_bit, key_zeroize,
    input  key_out, key_valid, key_err, busy, lockout, fail_cnt
  );

  modport slave (
    input  key_start, key_bit_vld, key_bit, key_zeroize,
    output key_out, key_valid, key_err, busy, lockout, fail_cnt
  );

endinterface

// File: rtl/sarlock_key_ctrl_shift.sv
// Serial-in shadow register for one key frame (key bits then parity), clear has priority.
module key_shift_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], bit_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/sarlock_key_ctrl.sv
// Key-delivery controller: serial frame capture, parity check, commit, and brute-force lockout.
//   state   | meaning
//   IDLE    | no key committed, waiting for key_start
//   SHIFT   | receiving KEY_W+1 frame bits, gap timer running
//   CHECK   | one-cycle parity / timeout verdict
//   VALID   | checked key driven on key_out
//   LOCKOUT | MAX_FAIL consecutive failures, inert until rst_n
module sarlock_key_ctrl
  import sarlock_pkg::*;
#(
  parameter int KEY_W    = 4,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sarlock_key_ctrl_if.slave bus
);

  localparam int BIT_CW = $clog2(KEY_W + 2);
  localparam int GAP_W  = $clog2(TIMEOUT + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  state_t              state_q;
  logic [BIT_CW-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]    gap_q;
  logic                tmo_q;
  logic [FAIL_W-1:0]   fail_cnt_q;
  logic [KEY_W-1:0]    key_out_q;
  logic                key_valid_q;
  logic                key_err_q;
  logic                busy_q;
  logic                lockout_q;

  logic [KEY_W:0]      sr_data;
  logic                zero_req;
  logic                start_req;
  logic                shift_en;

  // Zeroize beats start; start beats a same-cycle data bit.
  assign zero_req  = bus.key_zeroize && (state_q != LOCKOUT);
  assign start_req = bus.key_start && !bus.key_zeroize &&
                     (state_q == IDLE || state_q == VALID || state_q == SHIFT);
  assign shift_en  = (state_q == SHIFT) && bus.key_bit_vld &&
                     !bus.key_start && !bus.key_zeroize;

  key_shift_reg #(.W(KEY_W + 1)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (zero_req || start_req),
    .shift_i (shift_en),
    .bit_i   (bus.key_bit),
    .data_o  (sr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_q       <= '0;
      tmo_q       <= 1'b0;
      fail_cnt_q  <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      if (zero_req) begin
        state_q     <= IDLE;
        key_out_q   <= '0;
        key_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        bit_cnt_q   <= '0;
        gap_q       <= '0;
        tmo_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE, VALID: begin
            if (start_req) begin
              state_q   <= SHIFT;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
              gap_q     <= '0;
              tmo_q     <= 1'b0;
            end
          end
          SHIFT: begin
            if (start_req) begin
              bit_cnt_q <= '0;
              gap_q     <= '0;
            end else if (shift_en) begin
              gap_q <= '0;
              if (bit_cnt_q == BIT_CW'(KEY_W)) begin
                state_q <= CHECK;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
              end
            end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
              tmo_q   <= 1'b1;
              state_q <= CHECK;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          CHECK: begin
            if (!tmo_q && parity_ok(32'(sr_data))) begin
              key_out_q   <= sr_data[KEY_W:1];
              key_valid_q <= 1'b1;
              fail_cnt_q  <= '0;
              busy_q      <= 1'b0;
              state_q     <= VALID;
            end else begin
              key_out_q   <= '0;
              key_valid_q <= 1'b0;
              key_err_q   <= 1'b1;
              busy_q      <= 1'b0;
              tmo_q       <= 1'b0;
              if (fail_cnt_q < FAIL_W'(MAX_FAIL)) begin
                fail_cnt_q <= fail_cnt_q + FAIL_W'(1);
              end
              if (int'(fail_cnt_q) + 1 >= MAX_FAIL) begin
                state_q   <= LOCKOUT;
                lockout_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          LOCKOUT: begin
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            lockout_q   <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.key_out   = key_out_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_err   = key_err_q;
  assign bus.busy      = busy_q;
  assign bus.lockout   = lockout_q;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_sarlock_key_ctrl.sv
// Directed bench for sarlock_key_ctrl with KEY_W=4, MAX_FAIL=3, TIMEOUT=16.
module tb_sarlock_key_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   err_pulses;
  int   err_base;
  logic found;

  sarlock_key_ctrl_if #(.KEY_W(4), .MAX_FAIL(3)) bus ();

  sarlock_key_ctrl #(.KEY_W(4), .MAX_FAIL(3), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.key_err === 1'b1) err_pulses++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
  endtask

  // Sends the top n bits of v, MSB first.
  task automatic send_bits(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_bit_vld = 1'b1;
      bus.key_bit     = v[4-i];
      tick();
    end
    bus.key_bit_vld = 1'b0;
    bus.key_bit     = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    err_pulses = 0;
    bus.key_start = 1'b0;
    bus.key_bit_vld = 1'b0;
    bus.key_bit = 1'b0;
    bus.key_zeroize = 1'b0;
    rst_n = 1'b0;
    tick(2);
    chk("reset_outputs", {bus.key_out, bus.key_valid, bus.key_err, bus.busy, bus.lockout, bus.fail_cnt}, 32'h0);
    rst_n = 1'b1;
    tick();

    // good frame 1011 + parity 1
    start_frame();
    send_bits(5'b10111, 5);
    chk("busy_in_check", bus.busy, 1);
    tick();
    chk("good_key_out", bus.key_out, 4'b1011);
    chk("good_key_valid", bus.key_valid, 1);
    chk("good_no_err", bus.key_err, 0);
    chk("good_busy_drop", bus.busy, 0);

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_key_out", bus.key_out, 0);
    chk("async_rst_valid", bus.key_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // zeroize in VALID
    start_frame();
    send_bits(5'b10111, 5);
    tick();
    chk("valid_before_zero", bus.key_valid, 1);
    bus.key_zeroize = 1'b1;
    tick();
    bus.key_zeroize = 1'b0;
    chk("zero_key_out", bus.key_out, 0);
    chk("zero_valid", bus.key_valid, 0);
    chk("zero_no_err", bus.key_err, 0);
    chk("zero_fail_cnt", bus.fail_cnt, 0);

    // restart mid-frame
    err_base = err_pulses;
    start_frame();
    send_bits(5'b11100, 3);
    start_frame();
    send_bits(5'b01100, 5);
    tick();
    chk("restart_key_out", bus.key_out, 4'b0110);
    chk("restart_valid", bus.key_valid, 1);
    chk("restart_no_err", err_pulses - err_base, 0);

    // three bad frames -> lockout
    for (int k = 1; k <= 3; k++) begin
      start_frame();
      send_bits(5'b10110, 5);
      tick();
      chk($sformatf("bad%0d_err", k), bus.key_err, 1);
      chk($sformatf("bad%0d_fail_cnt", k), bus.fail_cnt, k);
      chk($sformatf("bad%0d_key_out", k), bus.key_out, 0);
      if (k == 1) begin
        bus.key_zeroize = 1'b1;
        tick();
        bus.key_zeroize = 1'b0;
        chk("zero_keeps_fail_cnt", bus.fail_cnt, 1);
        chk("zero_err_clear", bus.key_err, 0);
      end
    end
    chk("lockout_set", bus.lockout, 1);
    tick();
    chk("err_one_cycle", bus.key_err, 0);
    start_frame();
    send_bits(5'b10111, 5);
    tick();
    chk("lock_key_out", bus.key_out, 0);
    chk("lock_valid", bus.key_valid, 0);
    chk("lock_sticky", bus.lockout, 1);
    chk("lock_fail_cnt", bus.fail_cnt, 3);

    rst_n = 1'b0;
    tick();
    chk("rst_clears_lock", {bus.lockout, bus.fail_cnt}, 0);
    rst_n = 1'b1;
    tick();

    // start and zeroize together: zeroize wins, stays idle
    bus.key_start = 1'b1;
    bus.key_zeroize = 1'b1;
    tick();
    bus.key_start = 1'b0;
    bus.key_zeroize = 1'b0;
    chk("start_zero_busy", bus.busy, 0);

    // gap timeout
    start_frame();
    send_bits(5'b10000, 2);
    tick(15);
    chk("tmo_not_early", bus.key_err, 0);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.key_err === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("tmo_err_seen", found, 1);
    chk("tmo_fail_cnt", bus.fail_cnt, 1);
    chk("tmo_idle_busy", bus.busy, 0);
    start_frame();
    send_bits(5'b10111, 5);
    tick();
    chk("tmo_recover_fail_cnt", bus.fail_cnt, 0);
    chk("tmo_recover_key", bus.key_out, 4'b1011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
